// File: rtl/npu_dispatch.sv
// NPU dispatcher: queues decoded NPU instructions, issues them to the NPU
// over a valid/ready channel, tracks outstanding requests in order and
// returns results to the register-file writeback port.
module npu_dispatch #(
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_issue_valid,
  input  logic            i_is_npu_matrix_mul,
  input  logic            i_is_npu_conv,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_stall,
  output logic            o_npu_req_valid,
  input  logic            i_npu_req_ready,
  output logic            o_npu_req_op,
  output logic [XLEN-1:0] o_npu_req_a,
  output logic [XLEN-1:0] o_npu_req_b,
  input  logic            i_npu_rsp_valid,
  input  logic [XLEN-1:0] i_npu_rsp_data,
  output logic            o_npu_rsp_ready,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy,
  output logic            o_err_spurious
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Command FIFO storage and bookkeeping
  logic            r_cmd_op [CMD_DEPTH];
  logic [XLEN-1:0] r_cmd_a  [CMD_DEPTH];
  logic [XLEN-1:0] r_cmd_b  [CMD_DEPTH];
  logic [4:0]      r_cmd_rd [CMD_DEPTH];
  logic [PW-1:0]   r_cmd_wptr;
  logic [PW-1:0]   r_cmd_rptr;
  logic [CW-1:0]   r_cmd_count;

  // In-order tag queue of destination registers for outstanding requests
  logic [4:0]      r_tag [MAX_OUTSTANDING];
  logic [TW-1:0]   r_tag_wptr;
  logic [TW-1:0]   r_tag_rptr;
  logic [OW-1:0]   r_outstanding;

  // Response side and writeback registers
  logic            r_rsp_ready;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_err_spurious;

  logic w_npu_instr;
  logic w_cmd_full;
  logic w_cmd_empty;
  logic w_push;
  logic w_issue;
  logic w_rsp_fire;
  logic w_rsp_accept;
  logic w_rsp_spurious;
  logic w_push_op;

  assign w_npu_instr    = i_issue_valid & (i_is_npu_matrix_mul | i_is_npu_conv);
  assign w_cmd_full     = (r_cmd_count == CW'(CMD_DEPTH));
  assign w_cmd_empty    = (r_cmd_count == '0);
  assign w_push         = w_npu_instr & ~w_cmd_full;
  // Matrix multiply takes priority when the decoder raises both flags
  assign w_push_op      = ~i_is_npu_matrix_mul;
  assign w_issue        = o_npu_req_valid & i_npu_req_ready;
  assign w_rsp_fire     = i_npu_rsp_valid & r_rsp_ready;
  assign w_rsp_accept   = w_rsp_fire & (r_outstanding != '0);
  assign w_rsp_spurious = w_rsp_fire & (r_outstanding == '0);

  assign o_stall         = w_npu_instr & w_cmd_full;
  assign o_npu_req_valid = ~w_cmd_empty & (r_outstanding < OW'(MAX_OUTSTANDING));
  assign o_npu_req_op    = r_cmd_op[r_cmd_rptr];
  assign o_npu_req_a     = r_cmd_a[r_cmd_rptr];
  assign o_npu_req_b     = r_cmd_b[r_cmd_rptr];
  assign o_npu_rsp_ready = r_rsp_ready;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;
  assign o_busy          = ~w_cmd_empty | (r_outstanding != '0);
  assign o_err_spurious  = r_err_spurious;

  // Write an accepted instruction into the FIFO slot at the write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        r_cmd_op[i] <= 1'b0;
        r_cmd_a[i]  <= '0;
        r_cmd_b[i]  <= '0;
        r_cmd_rd[i] <= '0;
      end
    end else if (w_push) begin
      r_cmd_op[r_cmd_wptr] <= w_push_op;
      r_cmd_a[r_cmd_wptr]  <= i_rs1_data;
      r_cmd_b[r_cmd_wptr]  <= i_rs2_data;
      r_cmd_rd[r_cmd_wptr] <= i_rd_addr;
    end
  end

  // FIFO pointers and occupancy; a push and pop together keep the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_push) begin
        r_cmd_wptr <= r_cmd_wptr + 1'b1;
      end
      if (w_issue) begin
        r_cmd_rptr <= r_cmd_rptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
        2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // Tag queue push on issue, pop on accepted response, outstanding count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag[i] <= '0;
      end
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_issue) begin
        r_tag[r_tag_wptr] <= r_cmd_rd[r_cmd_rptr];
        r_tag_wptr <= (r_tag_wptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_wptr + 1'b1;
      end
      if (w_rsp_accept) begin
        r_tag_rptr <= (r_tag_rptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_rptr + 1'b1;
      end
      case ({w_issue, w_rsp_accept})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Registered writeback strobe, sticky spurious flag and response ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_ready    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_rsp_ready <= 1'b1;
      r_wb_valid  <= w_rsp_accept;
      if (w_rsp_accept) begin
        r_wb_rd   <= r_tag[r_tag_rptr];
        r_wb_data <= i_npu_rsp_data;
      end
      if (w_rsp_spurious) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_dispatch.sv
// Directed self-checking bench for npu_dispatch with hand-computed
// expected request and writeback sequences.
module tb_npu_dispatch;

  logic        clock = 1'b0;
  logic        rstN;
  logic        issueValid;
  logic        isMatMul;
  logic        isConv;
  logic [63:0] rs1Data;
  logic [63:0] rs2Data;
  logic [4:0]  rdAddr;
  logic        stall;
  logic        reqValid;
  logic        reqReady;
  logic        reqOpOut;
  logic [63:0] reqAOut;
  logic [63:0] reqBOut;
  logic        rspValid;
  logic [63:0] rspData;
  logic        rspReady;
  logic        wbValid;
  logic [4:0]  wbRdOut;
  logic [63:0] wbDataOut;
  logic        busy;
  logic        errSpurious;

  int checks = 0;
  int errors = 0;

  // Observed handshake history gathered by the monitor
  logic [63:0] reqA[$];
  logic        reqOp[$];
  logic [4:0]  wbRd[$];
  logic [63:0] wbData[$];
  int          rspCnt = 0;

  npu_dispatch #(.CMD_DEPTH(4), .MAX_OUTSTANDING(4), .XLEN(64)) dut (
    .i_clk               (clock),
    .i_rst_n             (rstN),
    .i_issue_valid       (issueValid),
    .i_is_npu_matrix_mul (isMatMul),
    .i_is_npu_conv       (isConv),
    .i_rs1_data          (rs1Data),
    .i_rs2_data          (rs2Data),
    .i_rd_addr           (rdAddr),
    .o_stall             (stall),
    .o_npu_req_valid     (reqValid),
    .i_npu_req_ready     (reqReady),
    .o_npu_req_op        (reqOpOut),
    .o_npu_req_a         (reqAOut),
    .o_npu_req_b         (reqBOut),
    .i_npu_rsp_valid     (rspValid),
    .i_npu_rsp_data      (rspData),
    .o_npu_rsp_ready     (rspReady),
    .o_wb_valid          (wbValid),
    .o_wb_rd             (wbRdOut),
    .o_wb_data           (wbDataOut),
    .o_busy              (busy),
    .o_err_spurious      (errSpurious)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Record every handshake that will complete on the next rising edge
  always @(negedge clock) begin
    if (rstN) begin
      if (reqValid && reqReady) begin
        reqA.push_back(reqAOut);
        reqOp.push_back(reqOpOut);
      end
      if (rspValid && rspReady) begin
        rspCnt <= rspCnt + 1;
      end
      if (wbValid) begin
        wbRd.push_back(wbRdOut);
        wbData.push_back(wbDataOut);
      end
    end
  end

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic mm, input logic cv,
                               input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                               input logic rdy, input logic rv, input logic [63:0] rdata);
    issueValid = iv;
    isMatMul   = mm;
    isConv     = cv;
    rs1Data    = a;
    rs2Data    = b;
    rdAddr     = rd;
    reqReady   = rdy;
    rspValid   = rv;
    rspData    = rdata;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Answer every outstanding request in order with dataBase, dataBase+1, ...
  task automatic drainResponses(input logic [63:0] dataBase, input int maxCycles);
    int  k = 0;
    bit  done = 0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      if (reqA.size() > rspCnt) begin
        rspValid = 1'b1;
        rspData  = dataBase + 64'(k);
        k++;
      end else begin
        rspValid = 1'b0;
      end
      #1;
      if (!rspValid && !busy) done = 1;
      else step();
    end
    rspValid = 1'b0;
    if (!done) checkOutput("drain_timeout", 64'(busy), 64'd0);
    step();
  endtask

  initial begin
    int reqBase;
    int wbBase;

    // Reset with all inputs quiet
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    checkOutput("rst_stall", 64'(stall), 0);
    checkOutput("rst_req_valid", 64'(reqValid), 0);
    checkOutput("rst_rsp_ready", 64'(rspReady), 0);
    checkOutput("rst_wb_valid", 64'(wbValid), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_err", 64'(errSpurious), 0);
    rstN = 1'b1;
    step();
    checkOutput("rsp_ready_after_rst", 64'(rspReady), 1);

    // Single matrix multiply, answered two cycles after issue
    applyStimulus(1, 1, 0, 64'h1000, 64'h20, 5, 1, 0, 0);
    checkOutput("single_stall", 64'(stall), 0);
    checkOutput("single_no_bypass", 64'(reqValid), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("single_req_valid", 64'(reqValid), 1);
    checkOutput("single_req_op", 64'(reqOpOut), 0);
    checkOutput("single_req_a", reqAOut, 64'h1000);
    checkOutput("single_req_b", reqBOut, 64'h20);
    step();
    checkOutput("single_req_done", 64'(reqValid), 0);
    checkOutput("single_busy", 64'(busy), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'hDEAD);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("single_wb_valid", 64'(wbValid), 1);
    checkOutput("single_wb_rd", 64'(wbRdOut), 5);
    checkOutput("single_wb_data", wbDataOut, 64'hDEAD);
    checkOutput("single_busy_end", 64'(busy), 0);
    step();
    checkOutput("single_wb_strobe", 64'(wbValid), 0);
    checkOutput("single_wb_hold", wbDataOut, 64'hDEAD);

    // Fill the FIFO with five conv ops while the NPU is not ready
    reqBase = reqA.size();
    wbBase  = wbRd.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 64'(i), 64'h40 + 64'(i), 5'(10 + i), 0, 0, 0);
      checkOutput("fill_accept", 64'(stall), 0);
      step();
    end
    applyStimulus(1, 0, 1, 64'd4, 64'h44, 5'd14, 0, 0, 0);
    checkOutput("fill_stall", 64'(stall), 1);
    applyStimulus(1, 0, 1, 64'd4, 64'h44, 5'd14, 1, 0, 0);
    checkOutput("fill_stall_no_ready_path", 64'(stall), 1);
    checkOutput("fill_head_a", reqAOut, 0);
    checkOutput("fill_head_op", 64'(reqOpOut), 1);
    step();
    checkOutput("fill_stall_release", 64'(stall), 0);
    checkOutput("fill_next_a", reqAOut, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    step();
    checkOutput("fill_limit_req_valid", 64'(reqValid), 0);
    checkOutput("fill_limit_busy", 64'(busy), 1);
    checkOutput("fill_limit_issued", 64'(reqA.size() - reqBase), 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'h500);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("fill_resume_valid", 64'(reqValid), 1);
    checkOutput("fill_resume_a", reqAOut, 4);
    drainResponses(64'h501, 60);
    checkOutput("fill_busy_end", 64'(busy), 0);
    checkOutput("fill_req_count", 64'(reqA.size() - reqBase), 5);
    checkOutput("fill_wb_count", 64'(wbRd.size() - wbBase), 5);
    for (int i = 0; i < 5; i++) begin
      if (reqA.size() > reqBase + i) begin
        checkOutput("fill_order_a", reqA[reqBase + i], 64'(i));
        checkOutput("fill_order_op", 64'(reqOp[reqBase + i]), 1);
      end
      if (wbRd.size() > wbBase + i) begin
        checkOutput("fill_wb_rd", 64'(wbRd[wbBase + i]), 64'(10 + i));
        checkOutput("fill_wb_data", wbData[wbBase + i], 64'h500 + 64'(i));
      end
    end

    // Outstanding limit: six ops with no responses
    reqBase = reqA.size();
    wbBase  = wbRd.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 0, 64'h100 + 64'(i), 64'h0, 5'(20 + i), 1, 0, 0);
      checkOutput("limit_accept", 64'(stall), 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    checkOutput("limit_req_valid", 64'(reqValid), 0);
    checkOutput("limit_issued", 64'(reqA.size() - reqBase), 4);
    checkOutput("limit_busy", 64'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'h600);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("limit_one_more_valid", 64'(reqValid), 1);
    checkOutput("limit_one_more_a", reqAOut, 64'h104);
    step();
    checkOutput("limit_blocked_again", 64'(reqValid), 0);
    drainResponses(64'h601, 60);
    checkOutput("limit_busy_end", 64'(busy), 0);
    checkOutput("limit_wb_count", 64'(wbRd.size() - wbBase), 6);
    for (int i = 0; i < 6; i++) begin
      if (wbRd.size() > wbBase + i) begin
        checkOutput("limit_wb_rd", 64'(wbRd[wbBase + i]), 64'(20 + i));
        checkOutput("limit_wb_data", wbData[wbBase + i], 64'h600 + 64'(i));
      end
    end

    // Ordering with a response landing in the same cycle as an issue
    applyStimulus(1, 1, 0, 64'h31, 0, 5'd1, 1, 0, 0);
    step();
    applyStimulus(1, 1, 0, 64'h32, 0, 5'd2, 1, 0, 0);
    step();
    applyStimulus(1, 1, 0, 64'h33, 0, 5'd3, 1, 1, 64'hA);
    checkOutput("order_issue_with_rsp", 64'(reqValid), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'hB);
    checkOutput("order_wb1_rd", 64'(wbRdOut), 1);
    checkOutput("order_wb1_data", wbDataOut, 64'hA);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'hC);
    checkOutput("order_wb2_rd", 64'(wbRdOut), 2);
    checkOutput("order_wb2_data", wbDataOut, 64'hB);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("order_wb3_valid", 64'(wbValid), 1);
    checkOutput("order_wb3_rd", 64'(wbRdOut), 3);
    checkOutput("order_wb3_data", wbDataOut, 64'hC);
    checkOutput("order_busy_end", 64'(busy), 0);
    step();

    // Spurious response while idle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'h77);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("spurious_err", 64'(errSpurious), 1);
    checkOutput("spurious_no_wb", 64'(wbValid), 0);
    step();
    checkOutput("spurious_sticky", 64'(errSpurious), 1);

    // Both decoder flags set resolves to matrix multiply
    applyStimulus(1, 1, 1, 64'h70, 64'h71, 5'd7, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("both_req_valid", 64'(reqValid), 1);
    checkOutput("both_req_op", 64'(reqOpOut), 0);
    checkOutput("both_req_a", reqAOut, 64'h70);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 64'h7777);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("both_wb_rd", 64'(wbRdOut), 7);
    checkOutput("both_wb_data", wbDataOut, 64'h7777);

    // Non-NPU instruction is ignored
    applyStimulus(1, 0, 0, 64'h90, 0, 5'd9, 1, 0, 0);
    checkOutput("non_npu_stall", 64'(stall), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("non_npu_req_valid", 64'(reqValid), 0);
    checkOutput("non_npu_busy", 64'(busy), 0);

    // Reset mid-operation with two ops queued
    applyStimulus(1, 0, 1, 64'h15, 0, 5'd15, 0, 0, 0);
    step();
    applyStimulus(1, 0, 1, 64'h16, 0, 5'd16, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_busy_before", 64'(busy), 1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_stall", 64'(stall), 0);
    checkOutput("midrst_req_valid", 64'(reqValid), 0);
    checkOutput("midrst_rsp_ready", 64'(rspReady), 0);
    checkOutput("midrst_wb_valid", 64'(wbValid), 0);
    checkOutput("midrst_wb_rd", 64'(wbRdOut), 0);
    checkOutput("midrst_wb_data", wbDataOut, 0);
    checkOutput("midrst_busy", 64'(busy), 0);
    checkOutput("midrst_err", 64'(errSpurious), 0);
    step();
    rstN = 1'b1;
    step();
    step();
    checkOutput("postrst_busy", 64'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h99);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("late_rsp_err", 64'(errSpurious), 1);
    checkOutput("late_rsp_no_wb", 64'(wbValid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_dispatch.md
Name: npu_dispatch

Overview:
- Sits directly downstream of the instruction decoder, which raises the one-hot flags is_npu_matrix_mul / is_npu_conv for OPCODE_NPU instructions.
- Captures decoded NPU instructions with their operands into a command FIFO and issues them to the NPU over a valid/ready request channel.
- Tracks outstanding requests in order, returns NPU results to the register-file writeback port, and stalls the pipeline when it cannot accept a new instruction.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- MAX_OUTSTANDING, 4, max requests issued to the NPU but not yet answered (power of 2, >=1).
- XLEN, 64, operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode stage holds a valid instruction this cycle.
- is_npu_matrix_mul  in  1  decoder flag: matrix-multiply op.
- is_npu_conv  in  1  decoder flag: convolution op.
- rs1_data  in  XLEN  operand A (descriptor base address).
- rs2_data  in  XLEN  operand B (descriptor config word).
- rd_addr  in  5  destination register.
- stall  out  1  hold the decode stage; the instruction is not accepted this cycle.
- npu_req_valid  out  1  request present.
- npu_req_ready  in  1  NPU accepts the request.
- npu_req_op  out  1  0 = matrix mul, 1 = conv.
- npu_req_a  out  XLEN  operand A.
- npu_req_b  out  XLEN  operand B.
- npu_rsp_valid  in  1  NPU result present.
- npu_rsp_data  in  XLEN  result.
- npu_rsp_ready  out  1  dispatcher accepts the result.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_rd  out  5  write-back register.
- wb_data  out  XLEN  write-back value.
- busy  out  1  any command queued or outstanding.
- err_spurious  out  1  sticky: a response arrived with nothing outstanding.

Behaviour:
- Reset (async assert, sync release): FIFO and tag queue empty, all counters 0. Outputs: stall=0, npu_req_valid=0, npu_rsp_ready=0, wb_valid=0, wb_rd=0, wb_data=0, busy=0, err_spurious=0.
- npu_instr = issue_valid & (is_npu_matrix_mul | is_npu_conv).
- stall = npu_instr & cmd_full.
  - Combinational from registered state only; no path from npu_req_ready.
  - A same-cycle pop does not release a full-FIFO stall.
- Push: on npu_instr & !cmd_full, write {op, rs1_data, rs2_data, rd_addr} at the write pointer.
  - op = 0 if is_npu_matrix_mul, otherwise 1.
  - If both flags are set, matrix mul wins.
- Issue: npu_req_valid = !cmd_empty & (outstanding < MAX_OUTSTANDING).
  - op, a and b are driven from the FIFO head and stay stable while valid & !ready.
  - Handshake fires on valid & ready: pop the head, push the head's rd onto the in-order tag queue, outstanding++.
- Pointers wrap modulo CMD_DEPTH. Full/empty are derived from a count (0..CMD_DEPTH). Simultaneous push and pop leave the count unchanged.
- npu_rsp_ready = 1 always (responses are never back-pressured).
- Accepted response (npu_rsp_valid & outstanding>0): the next cycle drives wb_valid=1, wb_rd = tag-queue head, wb_data = npu_rsp_data. The tag is popped and outstanding-- (latency 1). Otherwise wb_valid=0; wb_rd and wb_data hold their last value.
- Issue and response in the same cycle: outstanding is unchanged and the tag queue pushes and pops correctly.
- A response when outstanding==0: dropped, no wb_valid, err_spurious set until reset.
- Responses are in order; the NPU never reorders.
- busy = !cmd_empty | (outstanding != 0).
- Minimum latency from accept to NPU request: 1 cycle (registered FIFO; no bypass).
- Reset mid-operation discards all queued and outstanding state; late NPU responses after reset raise err_spurious.

Test Plan:
- Single op: issue matmul with rs1=0x1000, rs2=0x20, rd=5; NPU ready; respond 0xDEAD two cycles later. -> req_valid in cycle +1 with op=0, a=0x1000, b=0x20; wb_valid with rd=5, data=0xDEAD one cycle after the response; busy falls to 0.
- Fill: hold npu_req_ready=0 and issue 5 conv ops back-to-back (CMD_DEPTH=4). -> first 4 accepted, stall=1 on the 5th. Raise ready: stall drops the cycle after the first pop; all 5 are issued in order with op=1.
- Outstanding limit: ready=1, no responses, 6 ops. -> exactly 4 handshakes, then req_valid=0 with 2 entries queued. One response -> one more request issues.
- Ordering: issue rd=1,2,3 and respond 0xA,0xB,0xC, with one response landing in the same cycle as a new issue. -> writebacks (1,0xA),(2,0xB),(3,0xC) and the outstanding count stays correct.
- Spurious/reset: rsp_valid while idle -> err_spurious=1, no wb. Assert rst_n=0 with 2 ops queued -> all outputs return to reset values immediately.
- Both flags set with rd=7 -> queued as op=0; non-NPU issue_valid -> nothing queued, stall=0.
